// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Control-path bundle between the multi-cycle controller, the
//               instruction decoder and the datapath.
//               master modport : controller side (decoder fields and
//                                handshakes in, enables/selects out)
//               slave modport  : decoder/datapath side
//               Decoder fields : opcode[6:0], rd_sel[4:0]
//               Handshakes     : imem_ready, dmem_ready, branch_taken
//               Enables/selects: imem_req, ir_load, dmem_req, dmem_we,
//                                alu_src_imm, alu_op[1:0], wb_sel[1:0],
//                                reg_write_en, pc_write, pc_sel
//               Status         : illegal_instr, state_out[2:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [4:0] rd_sel;
    logic       imem_ready;
    logic       dmem_ready;
    logic       branch_taken;

    logic       imem_req;
    logic       ir_load;
    logic       dmem_req;
    logic       dmem_we;
    logic       alu_src_imm;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       reg_write_en;
    logic       pc_write;
    logic       pc_sel;
    logic       illegal_instr;
    logic [2:0] state_out;

    modport master (
        input  opcode, rd_sel, imem_ready, dmem_ready, branch_taken,
        output imem_req, ir_load, dmem_req, dmem_we, alu_src_imm, alu_op,
               wb_sel, reg_write_en, pc_write, pc_sel, illegal_instr,
               state_out
    );

    modport slave (
        output opcode, rd_sel, imem_ready, dmem_ready, branch_taken,
        input  imem_req, ir_load, dmem_req, dmem_we, alu_src_imm, alu_op,
               wb_sel, reg_write_en, pc_write, pc_sel, illegal_instr,
               state_out
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle control FSM for the RISC-V core. Sequences each
//               instruction through FETCH, DECODE, EXECUTE, MEM, WRITEBACK
//               (or TRAP on an illegal opcode) and drives the IR, register
//               file, ALU, data-memory and PC enables/selects.
// Ports       : clk            rising-edge clock
//               rst_n          asynchronous active-low reset
//               bus            multicycle_ctrl_if.master (decoder fields,
//                              memory/ALU handshakes, control outputs)
//               retired_cnt    retired-instruction counter (optional)
//               cycle_cnt      cycle counter (optional)
// Parameter   : RESET_PC_SEL   pc_sel value whenever pc_write is 0
// Macro       : CTRL_PERF_CNT_EN - when defined, adds the retired_cnt and
//               cycle_cnt ports and their counters.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter logic RESET_PC_SEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       cycle_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    state_t     r_state;
    state_t     w_state_next;
    logic [6:0] r_opcode;

    // Instruction class of the latched opcode (valid from EXECUTE onwards)
    logic w_is_r, w_is_i, w_is_lui, w_is_load, w_is_store, w_is_branch, w_is_jal;
    logic w_live_legal;

    logic [1:0] w_cls_alu_op;
    logic       w_cls_alu_src_imm;

    logic       w_imem_req, w_ir_load, w_dmem_req, w_dmem_we, w_alu_src_imm;
    logic [1:0] w_alu_op, w_wb_sel;
    logic       w_reg_write_en, w_pc_write, w_pc_sel, w_illegal_instr;

    assign w_is_r      = (r_opcode == c_op_r);
    assign w_is_i      = (r_opcode == c_op_i);
    assign w_is_lui    = (r_opcode == c_op_lui);
    assign w_is_load   = (r_opcode == c_op_load);
    assign w_is_store  = (r_opcode == c_op_store);
    assign w_is_branch = (r_opcode == c_op_branch);
    assign w_is_jal    = (r_opcode == c_op_jal);

    // Legality is judged on the live decoder opcode while in DECODE
    always_comb begin
        w_live_legal = 1'b0;
        case (bus.opcode)
            c_op_r, c_op_i, c_op_lui, c_op_load,
            c_op_store, c_op_branch, c_op_jal: w_live_legal = 1'b1;
            default:                           w_live_legal = 1'b0;
        endcase
    end

    // ALU operand/op selects per class. The ALU result feeds the datapath
    // unregistered, so these are held through MEM and WRITEBACK as well.
    always_comb begin
        w_cls_alu_op      = 2'b00;
        w_cls_alu_src_imm = 1'b0;
        if (w_is_r) begin
            w_cls_alu_op = 2'b01;
        end else if (w_is_i) begin
            w_cls_alu_op      = 2'b01;
            w_cls_alu_src_imm = 1'b1;
        end else if (w_is_load || w_is_store) begin
            w_cls_alu_src_imm = 1'b1;
        end else if (w_is_branch) begin
            w_cls_alu_op = 2'b10;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Opcode capture on the DECODE -> EXECUTE transition only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= 7'd0;
        end else if (r_state == ST_DECODE && w_state_next == ST_EXECUTE) begin
            r_opcode <= bus.opcode;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_next    = r_state;
        w_imem_req      = 1'b0;
        w_ir_load       = 1'b0;
        w_dmem_req      = 1'b0;
        w_dmem_we       = 1'b0;
        w_alu_src_imm   = 1'b0;
        w_alu_op        = 2'b00;
        w_wb_sel        = 2'b00;
        w_reg_write_en  = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_sel        = RESET_PC_SEL;
        w_illegal_instr = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_imem_req = 1'b1;
                // Gated by rst_n so the IR cannot load while reset is held
                w_ir_load  = bus.imem_ready & rst_n;
                if (bus.imem_ready) begin
                    w_state_next = ST_DECODE;
                end
            end

            ST_DECODE: begin
                w_state_next = w_live_legal ? ST_EXECUTE : ST_TRAP;
            end

            ST_EXECUTE: begin
                w_alu_op      = w_cls_alu_op;
                w_alu_src_imm = w_cls_alu_src_imm;
                if (w_is_branch) begin
                    w_pc_write   = 1'b1;
                    w_pc_sel     = bus.branch_taken;
                    w_state_next = ST_FETCH;
                end else if (w_is_load || w_is_store) begin
                    w_state_next = ST_MEM;
                end else begin
                    w_state_next = ST_WRITEBACK;
                end
            end

            ST_MEM: begin
                w_alu_op      = w_cls_alu_op;
                w_alu_src_imm = w_cls_alu_src_imm;
                w_dmem_req    = 1'b1;
                w_dmem_we     = w_is_store;
                if (bus.dmem_ready) begin
                    if (w_is_store) begin
                        // A store retires here; it never visits WRITEBACK
                        w_pc_write   = 1'b1;
                        w_pc_sel     = 1'b0;
                        w_state_next = ST_FETCH;
                    end else begin
                        w_state_next = ST_WRITEBACK;
                    end
                end
            end

            ST_WRITEBACK: begin
                w_alu_op       = w_cls_alu_op;
                w_alu_src_imm  = w_cls_alu_src_imm;
                w_reg_write_en = (bus.rd_sel != 5'd0);
                if (w_is_load) begin
                    w_wb_sel = 2'b01;
                end else if (w_is_jal) begin
                    w_wb_sel = 2'b10;
                end else if (w_is_lui) begin
                    w_wb_sel = 2'b11;
                end else begin
                    w_wb_sel = 2'b00;
                end
                w_pc_write   = 1'b1;
                w_pc_sel     = w_is_jal;
                w_state_next = ST_FETCH;
            end

            ST_TRAP: begin
                // Sticky until reset: state never leaves TRAP on its own
                w_illegal_instr = 1'b1;
            end

            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    assign bus.imem_req      = w_imem_req;
    assign bus.ir_load       = w_ir_load;
    assign bus.dmem_req      = w_dmem_req;
    assign bus.dmem_we       = w_dmem_we;
    assign bus.alu_src_imm   = w_alu_src_imm;
    assign bus.alu_op        = w_alu_op;
    assign bus.wb_sel        = w_wb_sel;
    assign bus.reg_write_en  = w_reg_write_en;
    assign bus.pc_write      = w_pc_write;
    assign bus.pc_sel        = w_pc_sel;
    assign bus.illegal_instr = w_illegal_instr;
    assign bus.state_out     = r_state;

`ifdef CTRL_PERF_CNT_EN
    // Both counters freeze once the core has trapped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= 32'd0;
            retired_cnt <= 32'd0;
        end else if (r_state != ST_TRAP) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (w_pc_write) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. Per-cycle vectors
//               of {inputs, expected outputs} plus hand-written sequences for
//               reset-from-TRAP, mid-instruction reset and the optional
//               performance counters (CTRL_PERF_CNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_bad    = 7'b1111111;

    logic clk;
    logic rst_n;

    multicycle_ctrl_if bus_if ();

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] cycle_cnt;
`endif

    multicycle_ctrl #(
        .RESET_PC_SEL (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if.master)
`ifdef CTRL_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .cycle_cnt   (cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector layout:
    // {state[2:0], imem_req, ir_load, dmem_req, dmem_we, alu_src_imm,
    //  alu_op[1:0], wb_sel[1:0], reg_write_en, pc_write, pc_sel, illegal}
    typedef struct {
        string       nm;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic        ir;
        logic        dr;
        logic        bt;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [15:0] mk(input logic [2:0] st, input logic ireq,
                                       input logic irl, input logic dreq,
                                       input logic dwe, input logic src,
                                       input logic [1:0] aop, input logic [1:0] wb,
                                       input logic rwe, input logic pcw,
                                       input logic pcs, input logic ill);
        return {st, ireq, irl, dreq, dwe, src, aop, wb, rwe, pcw, pcs, ill};
    endfunction

    function automatic logic [15:0] actual();
        return {bus_if.state_out, bus_if.imem_req, bus_if.ir_load,
                bus_if.dmem_req, bus_if.dmem_we, bus_if.alu_src_imm,
                bus_if.alu_op, bus_if.wb_sel, bus_if.reg_write_en,
                bus_if.pc_write, bus_if.pc_sel, bus_if.illegal_instr};
    endfunction

    task automatic add(input string nm, input logic [6:0] op, input logic [4:0] rd,
                       input logic ir, input logic dr, input logic bt,
                       input logic [15:0] exp);
        vec_t v;
        v.nm = nm; v.op = op; v.rd = rd; v.ir = ir; v.dr = dr; v.bt = bt; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic [6:0] op, input logic [4:0] rd,
                         input logic ir, input logic dr, input logic bt);
        bus_if.opcode       = op;
        bus_if.rd_sel       = rd;
        bus_if.imem_ready   = ir;
        bus_if.dmem_ready   = dr;
        bus_if.branch_taken = bt;
    endtask

    task automatic check_vec(input string nm, input logic [15:0] exp);
        logic [15:0] a;
        a = actual();
        n_checks++;
        if (a !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, a, exp);
        end
    endtask

    task automatic check_val(input string nm, input logic [31:0] a, input logic [31:0] exp);
        n_checks++;
        if (a !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, a, exp);
        end
    endtask

    // Called at posedge+1: drive inputs, check mid-cycle, advance one clock
    task automatic run_row(input vec_t v);
        apply(v.op, v.rd, v.ir, v.dr, v.bt);
        #2;
        check_vec(v.nm, v.exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- vector table (one row per clock) ----
        // addi x1: 0,1,2,4
        add("addi_f", c_op_i, 5'd1, 1, 1, 0, mk(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
        add("addi_d", c_op_i, 5'd1, 1, 1, 0, mk(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
        add("addi_e", c_op_i, 5'd1, 1, 1, 0, mk(2,0,0,0,0,1,2'b01,2'b00,0,0,0,0));
        add("addi_w", c_op_i, 5'd1, 1, 1, 0, mk(4,0,0,0,0,1,2'b01,2'b00,1,1,0,0));
        // load x5, dmem_ready low 3 cycles: 8 cycles total
        add("ld_f",   c_op_load, 5'd5, 1, 1, 0, mk(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
        add("ld_d",   c_op_load, 5'd5, 1, 1, 0, mk(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
        add("ld_e",   c_op_load, 5'd5, 1, 1, 0, mk(2,0,0,0,0,1,2'b00,2'b00,0,0,0,0));
        add("ld_m0",  c_op_load, 5'd5, 1, 0, 0, mk(3,0,0,1,0,1,2'b00,2'b00,0,0,0,0));
        add("ld_m1",  c_op_load, 5'd5, 1, 0, 0, mk(3,0,0,1,0,1,2'b00,2'b00,0,0,0,0));
        add("ld_m2",  c_op_load, 5'd5, 1, 0, 0, mk(3,0,0,1,0,1,2'b00,2'b00,0,0,0,0));
        add("ld_m3",  c_op_load, 5'd5, 1, 1, 0, mk(3,0,0,1,0,1,2'b00,2'b00,0,0,0,0));
        add("ld_w",   c_op_load, 5'd5, 1, 1, 0, mk(4,0,0,0,0,1,2'b00,2'b01,1,1,0,0));
        // branch taken
        add("bt_f",   c_op_branch, 5'd0, 1, 1, 0, mk(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
        add("bt_d",   c_op_branch, 5'd0, 1, 1, 0, mk(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
        add("bt_e",   c_op_branch, 5'd0, 1, 1, 1, mk(2,0,0,0,0,0,2'b10,2'b00,0,1,1,0));
        // branch not taken; branch_taken high outside EXECUTE is ignored
        add("bn_f",   c_op_branch, 5'd0, 1, 1, 1, mk(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
        add("bn_d",   c_op_branch, 5'd0, 1, 1, 1, mk(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
        add("bn_e",   c_op_branch, 5'd0, 1, 1, 0, mk(2,0,0,0,0,0,2'b10,2'b00,0,1,0,0));
        // jal x0
        add("jal_f",  c_op_jal, 5'd0, 1, 1, 0, mk(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
        add("jal_d",  c_op_jal, 5'd0, 1, 1, 0, mk(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
        add("jal_e",  c_op_jal, 5'd0, 1, 1, 0, mk(2,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
        add("jal_w",  c_op_jal, 5'd0, 1, 1, 0, mk(4,0,0,0,0,0,2'b00,2'b10,0,1,1,0));
        // store with one imem wait; live opcode changes in MEM (latched wins)
        add("st_f0",  c_op_store, 5'd7, 0, 1, 0, mk(0,1,0,0,0,0,2'b00,2'b00,0,0,0,0));
        add("st_f1",  c_op_store, 5'd7, 1, 1, 0, mk(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
        add("st_d",   c_op_store, 5'd7, 1, 1, 0, mk(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
        add("st_e",   c_op_store, 5'd7, 1, 1, 0, mk(2,0,0,0,0,1,2'b00,2'b00,0,0,0,0));
        add("st_m0",  c_op_load,  5'd7, 1, 0, 0, mk(3,0,0,1,1,1,2'b00,2'b00,0,0,0,0));
        add("st_m1",  c_op_load,  5'd7, 1, 1, 0, mk(3,0,0,1,1,1,2'b00,2'b00,0,1,0,0));
        // lui x3
        add("lui_f",  c_op_lui, 5'd3, 1, 1, 0, mk(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
        add("lui_d",  c_op_lui, 5'd3, 1, 1, 0, mk(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
        add("lui_e",  c_op_lui, 5'd3, 1, 1, 0, mk(2,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
        add("lui_w",  c_op_lui, 5'd3, 1, 1, 0, mk(4,0,0,0,0,0,2'b00,2'b11,1,1,0,0));
        // R-type x2; branch_taken ignored in non-branch EXECUTE
        add("r_f",    c_op_r, 5'd2, 1, 1, 0, mk(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
        add("r_d",    c_op_r, 5'd2, 1, 1, 0, mk(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
        add("r_e",    c_op_r, 5'd2, 1, 1, 1, mk(2,0,0,0,0,0,2'b01,2'b00,0,0,0,0));
        add("r_w",    c_op_r, 5'd2, 1, 1, 1, mk(4,0,0,0,0,0,2'b01,2'b00,1,1,0,0));
        // illegal opcode: TRAP in cycle 3, sticky
        add("ill_f",  c_op_bad, 5'd1, 1, 1, 0, mk(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
        add("ill_d",  c_op_bad, 5'd1, 1, 1, 0, mk(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
        add("trap0",  c_op_bad, 5'd1, 1, 1, 1, mk(5,0,0,0,0,0,2'b00,2'b00,0,0,0,1));
        add("trap1",  c_op_i,   5'd1, 1, 1, 1, mk(5,0,0,0,0,0,2'b00,2'b00,0,0,0,1));
        add("trap2",  c_op_r,   5'd1, 1, 1, 0, mk(5,0,0,0,0,0,2'b00,2'b00,0,0,0,1));

        // ---- reset state ----
        rst_n = 1'b0;
        apply(c_op_i, 5'd1, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        check_vec("reset_state", mk(0,1,0,0,0,0,2'b00,2'b00,0,0,0,0));
`ifdef CTRL_PERF_CNT_EN
        check_val("reset_cycle_cnt", cycle_cnt, 32'd0);
        check_val("reset_retired_cnt", retired_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            run_row(vecs[i]);
        end

        // ---- async reset out of TRAP ----
        #1;
        rst_n = 1'b0;
        apply(c_op_bad, 5'd1, 1'b1, 1'b1, 1'b1);
        #1;
        check_vec("trap_async_rst", mk(0,1,0,0,0,0,2'b00,2'b00,0,0,0,0));
        @(posedge clk);
        #1;
        check_vec("trap_rst_held", mk(0,1,0,0,0,0,2'b00,2'b00,0,0,0,0));
        rst_n = 1'b1;

        // ---- three back-to-back addi from a fresh reset ----
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                run_row(vecs[i]);
            end
        end
`ifdef CTRL_PERF_CNT_EN
        check_val("retired_after_3", retired_cnt, 32'd3);
        check_val("cycles_after_3", cycle_cnt, 32'd12);
`endif

        // ---- reset mid-EXECUTE ----
        run_row(vecs[0]);
        run_row(vecs[1]);
        apply(c_op_i, 5'd1, 1'b1, 1'b1, 1'b0);
        #1;
        check_vec("mid_exec_pre", mk(2,0,0,0,0,1,2'b01,2'b00,0,0,0,0));
        rst_n = 1'b0;
        #1;
        check_vec("mid_exec_rst", mk(0,1,0,0,0,0,2'b00,2'b00,0,0,0,0));
`ifdef CTRL_PERF_CNT_EN
        check_val("mid_exec_cycle_cnt", cycle_cnt, 32'd0);
        check_val("mid_exec_retired_cnt", retired_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        check_vec("post_rst_fetch", mk(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
